fetch_stage: RTL and testbench

Front stage of the RV32I multicycle pipeline: owns the program counter, issues one instruction-memory read at a time, holds the fetched word and hands it to decode over the same ready-to-send / ready-to-receive handshake the other stages use. It redirects on `misPredict`/`reqPc` from execute, discarding any wrong-path instruction, including a memory read already in flight.

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared pipeline definitions for the fetch stage: one-hot state
//               codes, instruction size and PC alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int unsigned c_ADDR_W = 32;

    localparam logic [3:0] c_ST_IDLE      = 4'b0001;
    localparam logic [3:0] c_ST_WAIT_MEM  = 4'b0010;
    localparam logic [3:0] c_ST_WAIT_SEND = 4'b0100;
    localparam logic [3:0] c_ST_FLUSH_MEM = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_WAIT_MEM  = c_ST_WAIT_MEM,
        ST_WAIT_SEND = c_ST_WAIT_SEND,
        ST_FLUSH_MEM = c_ST_FLUSH_MEM
    } fetch_state_t;

    localparam int unsigned c_INSTR_BYTES = 4;

    function automatic logic [c_ADDR_W-1:0] align_pc(input logic [c_ADDR_W-1:0] addr);
        return {addr[c_ADDR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I multicycle fetch stage. Owns the PC, issues one
//               instruction read at a time and hands the word to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned                 XLEN           = 32,
    parameter int unsigned                 READ_ADDR_SIZE = 32,
    parameter logic [READ_ADDR_SIZE-1:0]   START_PC       = '0
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startSig,
    input  logic                      nextPipReadyToRcv,
    input  logic                      misPredict,
    input  logic [READ_ADDR_SIZE-1:0] reqPc,
    input  logic                      mem_readFin,
    input  logic [XLEN-1:0]           mem_readData,
    output logic                      mem_readEn,
    output logic [READ_ADDR_SIZE-1:0] mem_readAddr,
    output logic [XLEN-1:0]           fetch_instr,
    output logic [READ_ADDR_SIZE-1:0] fetch_pc,
    output logic [READ_ADDR_SIZE-1:0] fetch_nextPc,
    output logic                      curPipReadyToSend
);

    fetch_state_t              r_state;
    fetch_state_t              w_state_nxt;
    logic [READ_ADDR_SIZE-1:0] r_pc;
    logic [READ_ADDR_SIZE-1:0] w_pc_nxt;
    logic [READ_ADDR_SIZE-1:0] r_redirect_pc;
    logic [READ_ADDR_SIZE-1:0] w_redirect_nxt;
    logic [XLEN-1:0]           r_instr;
    logic [XLEN-1:0]           w_instr_nxt;
    logic [READ_ADDR_SIZE-1:0] w_pc_plus4;
    logic [READ_ADDR_SIZE-1:0] w_req_aligned;
    logic                      w_read_en;
    logic                      w_send;

    assign w_pc_plus4    = r_pc + READ_ADDR_SIZE'(c_INSTR_BYTES);
    assign w_req_aligned = align_pc(reqPc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= START_PC;
            r_redirect_pc <= '0;
            r_instr       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redirect_pc <= w_redirect_nxt;
            r_instr       <= w_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = r_redirect_pc;
        w_instr_nxt    = r_instr;
        w_read_en      = 1'b0;
        w_send         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (startSig) begin
                    w_pc_nxt    = START_PC;
                    w_state_nxt = ST_WAIT_MEM;
                end
            end

            ST_WAIT_MEM: begin
                w_read_en = 1'b1;
                if (mem_readFin && !misPredict) begin
                    w_instr_nxt = mem_readData;
                    w_state_nxt = ST_WAIT_SEND;
                end else if (mem_readFin && misPredict) begin
                    w_pc_nxt = w_req_aligned;
                end else if (misPredict) begin
                    w_redirect_nxt = w_req_aligned;
                    w_state_nxt    = ST_FLUSH_MEM;
                end
            end

            // The in-flight read keeps its original address until it returns;
            // its data is discarded and the latest redirect target is used.
            ST_FLUSH_MEM: begin
                w_read_en = 1'b1;
                if (mem_readFin) begin
                    w_pc_nxt    = misPredict ? w_req_aligned : r_redirect_pc;
                    w_state_nxt = ST_WAIT_MEM;
                end else if (misPredict) begin
                    w_redirect_nxt = w_req_aligned;
                end
            end

            ST_WAIT_SEND: begin
                w_send = !misPredict;
                if (misPredict) begin
                    w_pc_nxt    = w_req_aligned;
                    w_state_nxt = ST_WAIT_MEM;
                end else if (nextPipReadyToRcv) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = ST_WAIT_MEM;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_readEn        = w_read_en;
    assign mem_readAddr      = r_pc;
    assign curPipReadyToSend = w_send;
    assign fetch_pc          = r_pc;
    assign fetch_nextPc      = w_pc_plus4;
    assign fetch_instr       = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a latency-controlled
//               instruction memory and an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_START = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        startSig;
    logic        nextPipReadyToRcv;
    logic        misPredict;
    logic [31:0] reqPc;
    logic        mem_readFin;
    logic [31:0] mem_readData;
    logic        mem_readEn;
    logic [31:0] mem_readAddr;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_nextPc;
    logic        curPipReadyToSend;

    fetch_stage #(
        .XLEN           (32),
        .READ_ADDR_SIZE (32),
        .START_PC       (c_START)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .startSig          (startSig),
        .nextPipReadyToRcv (nextPipReadyToRcv),
        .misPredict        (misPredict),
        .reqPc             (reqPc),
        .mem_readFin       (mem_readFin),
        .mem_readData      (mem_readData),
        .mem_readEn        (mem_readEn),
        .mem_readAddr      (mem_readAddr),
        .fetch_instr       (fetch_instr),
        .fetch_pc          (fetch_pc),
        .fetch_nextPc      (fetch_nextPc),
        .curPipReadyToSend (curPipReadyToSend)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mem_wait = 0;
    int          n_xfer = 0;
    logic        started = 1'b0;
    logic [31:0] exp_pc = c_START;

    logic        d_rst = 1'b1, d_start = 1'b0, d_mis = 1'b0, d_rdy = 1'b0, d_fin_force = 1'b0;
    logic [31:0] d_req = '0;
    logic        t_req, t_xfer;
    logic [31:0] t_req_addr;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    // One clock cycle: apply inputs, play memory, check against the stream model.
    task automatic tick();
        logic        fin;
        logic [31:0] data;
        t_req  = 1'b0;
        t_xfer = 1'b0;
        fin    = 1'b0;
        data   = $urandom;
        rst = d_rst; startSig = d_start; misPredict = d_mis; reqPc = d_req; nextPipReadyToRcv = d_rdy;
        if (d_fin_force) begin
            fin = 1'b1;
        end else if (mem_readEn) begin
            if (mem_wait == 0) begin
                t_req = 1'b1; t_req_addr = mem_readAddr;
            end
            if (mem_wait >= lat) begin
                fin = 1'b1; data = img(mem_readAddr); mem_wait = 0;
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
        mem_readFin = fin; mem_readData = data;
        #1;
        if (!d_rst && !started) begin
            checks++;
            if (mem_readEn !== 1'b0 || curPipReadyToSend !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: readEn=%b send=%b expected 0/0", mem_readEn, curPipReadyToSend);
            end
        end else if (!d_rst) begin
            if (t_req) begin
                checks++;
                if (t_req_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h expected %h (cyc %0d)", t_req_addr, exp_pc, cyc);
                end
            end
            if (misPredict || mem_readEn) begin
                checks++;
                if (curPipReadyToSend !== 1'b0) begin
                    errors++;
                    $display("FAIL send_blocked: send=%b expected 0 (mis=%b readEn=%b)", curPipReadyToSend, misPredict, mem_readEn);
                end
            end
            if (curPipReadyToSend === 1'b1 && nextPipReadyToRcv) begin
                t_xfer = 1'b1;
                n_xfer++;
                checks++;
                if (fetch_pc !== exp_pc || fetch_instr !== img(exp_pc) || fetch_nextPc !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL transfer: pc=%h instr=%h next=%h expected pc=%h instr=%h next=%h",
                             fetch_pc, fetch_instr, fetch_nextPc, exp_pc, img(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (misPredict) exp_pc = {reqPc[31:2], 2'b00};
        end
        if (d_rst) begin
            started = 1'b0; exp_pc = c_START; mem_wait = 0;
        end else if (d_start && !started) begin
            started = 1'b1; exp_pc = c_START;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_send();
        int n = 0;
        while (!(started && !mem_readEn)) begin
            tick();
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL wait_send: timeout got 0 expected 1");
                return;
            end
        end
    endtask

    task automatic wait_new_req();
        int n = 0;
        while (!(mem_readEn && mem_wait == 0)) begin
            tick();
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL wait_req: timeout got 0 expected 1");
                return;
            end
        end
    endtask

    task automatic do_reset();
        d_rst = 1'b1; d_start = 1'b0; d_mis = 1'b0; d_rdy = 1'b0;
        tick(); tick();
        d_rst = 1'b0;
    endtask

    task automatic start_fetch();
        d_start = 1'b1; tick(); d_start = 1'b0;
    endtask

    task automatic redirect_in_send(input logic [31:0] tgt);
        d_rdy = 1'b0;
        wait_send();
        d_mis = 1'b1; d_req = tgt; tick(); d_mis = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_readEn !== 1'b0 || curPipReadyToSend !== 1'b0 || fetch_pc !== c_START ||
            fetch_nextPc !== c_START + 32'd4 || fetch_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: en=%b send=%b pc=%h next=%h instr=%h expected 0 0 %h %h 0",
                     mem_readEn, curPipReadyToSend, fetch_pc, fetch_nextPc, fetch_instr, c_START, c_START + 32'd4);
        end
        // misPredict in idle must be ignored; first fetch still at START_PC
        d_mis = 1'b1; d_req = 32'h100; tick(); d_mis = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        int          xc[$];
        logic [31:0] ra[$];
        lat = 1; d_rdy = 1'b1;
        start_fetch();
        checks++;
        if (mem_readEn !== 1'b1 || mem_readAddr !== c_START) begin
            errors++;
            $display("FAIL start_latency: en=%b addr=%h expected 1 %h", mem_readEn, mem_readAddr, c_START);
        end
        repeat (12) begin
            tick();
            if (t_req)  ra.push_back(t_req_addr);
            if (t_xfer) xc.push_back(cyc);
        end
        checks++;
        if (ra.size() < 3 || xc.size() < 3) begin
            errors++;
            $display("FAIL seq_counts: reqs=%0d xfers=%0d expected >=3", ra.size(), xc.size());
        end else begin
            if (ra[0] !== 32'h0 || ra[1] !== 32'h4 || ra[2] !== 32'h8) begin
                errors++;
                $display("FAIL seq_addrs: got %h %h %h expected 0 4 8", ra[0], ra[1], ra[2]);
            end
            checks++;
            if (xc[1] - xc[0] != 3 || xc[2] - xc[1] != 3) begin
                errors++;
                $display("FAIL seq_throughput: got %0d %0d expected 3 3", xc[1] - xc[0], xc[2] - xc[1]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, i0;
        lat = 1; d_rdy = 1'b0;
        wait_send();
        pc0 = fetch_pc; i0 = fetch_instr;
        repeat (5) begin
            tick();
            checks++;
            if (fetch_pc !== pc0 || fetch_instr !== i0 || mem_readEn !== 1'b0 || curPipReadyToSend !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: pc=%h instr=%h en=%b send=%b expected %h %h 0 1",
                         fetch_pc, fetch_instr, mem_readEn, curPipReadyToSend, pc0, i0);
            end
        end
        d_rdy = 1'b1; tick();
        checks++;
        if (t_xfer !== 1'b1 || mem_readEn !== 1'b1 || mem_readAddr !== pc0 + 32'd4) begin
            errors++;
            $display("FAIL stall_release: xfer=%b en=%b addr=%h expected 1 1 %h", t_xfer, mem_readEn, mem_readAddr, pc0 + 32'd4);
        end
    endtask

    task automatic test_mispredict_send();
        d_rdy = 1'b0;
        wait_send();
        d_mis = 1'b1; d_req = 32'h40; d_rdy = 1'b1; tick(); d_mis = 1'b0;
        checks++;
        if (t_xfer !== 1'b0 || mem_readEn !== 1'b1 || mem_readAddr !== 32'h40) begin
            errors++;
            $display("FAIL mis_send: xfer=%b en=%b addr=%h expected 0 1 00000040", t_xfer, mem_readEn, mem_readAddr);
        end
    endtask

    task automatic test_flush();
        int   n = 0;
        logic saw_send = 1'b0;
        redirect_in_send(32'h10);
        lat = 3;
        tick();
        d_mis = 1'b1; d_req = 32'h80; tick(); d_mis = 1'b0;
        while (!(mem_readEn && mem_wait == 0) && n < 10) begin
            checks++;
            if (mem_readEn !== 1'b1 || mem_readAddr !== 32'h10) begin
                errors++;
                $display("FAIL flush_addr: en=%b addr=%h expected 1 00000010", mem_readEn, mem_readAddr);
            end
            tick();
            saw_send |= curPipReadyToSend;
            n++;
        end
        checks++;
        if (n != 2 || mem_readAddr !== 32'h80 || saw_send) begin
            errors++;
            $display("FAIL flush_redirect: ticks=%0d addr=%h send_seen=%b expected 2 00000080 0", n, mem_readAddr, saw_send);
        end
    endtask

    task automatic test_multi_redirect();
        redirect_in_send(32'h20);
        lat = 3;
        d_mis = 1'b1; d_req = 32'h80; tick();
        d_req = 32'hC0; tick(); d_mis = 1'b0;
        wait_new_req();
        checks++;
        if (mem_readAddr !== 32'hC0) begin
            errors++;
            $display("FAIL latest_target: got %h expected 000000c0", mem_readAddr);
        end
        lat = 1;
        tick();
        d_mis = 1'b1; d_req = 32'h43; tick(); d_mis = 1'b0;
        checks++;
        if (mem_readEn !== 1'b1 || mem_readAddr !== 32'h40 || mem_wait != 0) begin
            errors++;
            $display("FAIL mis_with_fin: en=%b addr=%h wait=%0d expected 1 00000040 0", mem_readEn, mem_readAddr, mem_wait);
        end
        d_rdy = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_wrap();
        redirect_in_send(32'hFFFF_FFFE);
        lat = 0;
        wait_send();
        checks++;
        if (fetch_pc !== 32'hFFFF_FFFC || fetch_nextPc !== 32'h0 || fetch_instr !== img(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_hold: pc=%h next=%h instr=%h expected fffffffc 00000000 %h",
                     fetch_pc, fetch_nextPc, fetch_instr, img(32'hFFFF_FFFC));
        end
        d_rdy = 1'b1; tick();
        checks++;
        if (mem_readEn !== 1'b1 || mem_readAddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: en=%b addr=%h expected 1 00000000", mem_readEn, mem_readAddr);
        end
    endtask

    task automatic test_rst_midread();
        lat = 5;
        wait_new_req();
        tick();
        d_rst = 1'b1; tick(); d_rst = 1'b0;
        d_fin_force = 1'b1; tick(); d_fin_force = 1'b0;
        repeat (2) begin
            checks++;
            if (mem_readEn !== 1'b0 || curPipReadyToSend !== 1'b0 || fetch_pc !== c_START) begin
                errors++;
                $display("FAIL rst_midread: en=%b send=%b pc=%h expected 0 0 %h", mem_readEn, curPipReadyToSend, fetch_pc, c_START);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int x0;
        do_reset();
        start_fetch();
        x0 = n_xfer;
        repeat (3000) begin
            if (mem_wait == 0) lat = $urandom_range(0, 3);
            d_rdy = ($urandom_range(0, 9) < 7);
            d_mis = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       d_req = $urandom;
                1:       d_req = $urandom_range(0, 255);
                default: d_req = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            tick();
        end
        d_mis = 1'b0;
        checks++;
        if (n_xfer - x0 < 100) begin
            errors++;
            $display("FAIL random_progress: got %0d transfers expected >=100", n_xfer - x0);
        end
    endtask

    initial begin
        rst = 1'b1; startSig = 1'b0; nextPipReadyToRcv = 1'b0; misPredict = 1'b0;
        reqPc = '0; mem_readFin = 1'b0; mem_readData = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_mispredict_send();
        test_flush();
        test_multi_redirect();
        test_wrap();
        test_rst_midread();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
